// File: rtl/rx_ddr_write_packer_pkg.sv
// Shared DDR write-path constants and types: word/address widths and the
// address+data entry buffered ahead of the controller write port.
package ddr_pkg;

  localparam int unsigned DATA_WIDTH = 256;
  localparam int unsigned ADDR_WIDTH = 25;

  typedef logic [DATA_WIDTH-1:0] ddr_word_t;
  typedef logic [ADDR_WIDTH-1:0] ddr_addr_t;

  typedef struct packed {
    ddr_addr_t addr;
    ddr_word_t data;
  } wr_entry_t;

endpackage

// File: rtl/rx_ddr_write_packer_if.sv
// RX byte stream in, DDR controller write port and status out.
interface rx_ddr_write_packer_if;
  import ddr_pkg::*;

  logic        rx_data_valid_unused_guard;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  ddr_addr_t   wr_addr;
  ddr_word_t   wr_data;
  logic        wr_en;
  logic        wr_busy;
  logic        overflow;
  logic [15:0] drop_count;
  logic [15:0] frame_count;

  // Packer side: consumes the byte stream and wr_busy, drives the write port.
  modport slave (
    input  rx_data, rx_valid, rx_last, wr_busy,
    output wr_addr, wr_data, wr_en, overflow, drop_count, frame_count
  );

  // Environment side: RX frame path plus the controller.
  modport master (
    output rx_data, rx_valid, rx_last, wr_busy,
    input  wr_addr, wr_data, wr_en, overflow, drop_count, frame_count
  );

endinterface

// File: rtl/rx_ddr_write_packer_fifo.sv
// Synchronous FIFO of address+data entries; the head is visible combinationally
// (first-word fall-through). Pointers carry one extra wrap bit for full/empty.
module ddr_wr_fifo
  import ddr_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  wr_entry_t i_entry,
  input  logic      i_pop,
  output wr_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  wr_entry_t       r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;

  // A push into a full FIFO is only issued together with a pop, so the slot
  // written is the one being vacated this cycle.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/rx_ddr_write_packer.sv
// Packs RX bytes into DDR words, tags each with a consecutive word address and
// buffers them in a FIFO until the controller write port is free.
module rx_ddr_write_packer
  import ddr_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter ddr_addr_t   BASE_ADDR  = '0
) (
  input logic                   clk,
  input logic                   rst_n,
  rx_ddr_write_packer_if.slave  bus
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(BYTES);

  logic [IDX_W-1:0] r_idx;
  ddr_word_t        r_shift;
  ddr_addr_t        r_addr;
  logic             r_overflow;
  logic [15:0]      r_drop_count;
  logic [15:0]      r_frame_count;

  ddr_word_t        w_word;
  logic             w_last;
  logic             w_complete;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  wr_entry_t        w_entry;
  wr_entry_t        w_head;

  // Upper bytes are already zero because the shift register clears on every
  // word completion, so an rx_last word needs no explicit padding.
  always_comb begin
    w_word = r_shift;
    w_word[{r_idx, 3'b000} +: 8] = bus.rx_data;
  end

  assign w_last     = bus.rx_valid && bus.rx_last;
  assign w_complete = bus.rx_valid && (bus.rx_last || (r_idx == IDX_W'(BYTES - 1)));
  assign w_pop      = bus.wr_en;
  assign w_push     = w_complete && (!w_full || w_pop);
  assign w_drop     = w_complete && w_full && !w_pop;

  assign w_entry.addr = r_addr;
  assign w_entry.data = w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (bus.rx_valid) begin
      if (w_complete) begin
        r_idx   <= '0;
        r_shift <= '0;
      end else begin
        r_idx   <= r_idx + 1'b1;
        r_shift <= w_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= BASE_ADDR;
      r_overflow    <= 1'b0;
      r_drop_count  <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_push) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_push && w_last) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != '1) begin
          r_drop_count <= r_drop_count + 1'b1;
        end
      end
    end
  end

  ddr_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.wr_en       = !w_empty && !bus.wr_busy;
  assign bus.wr_addr     = w_empty ? '0 : w_head.addr;
  assign bus.wr_data     = w_empty ? '0 : w_head.data;
  assign bus.overflow    = r_overflow;
  assign bus.drop_count  = r_drop_count;
  assign bus.frame_count = r_frame_count;

endmodule
